// File: rtl/counter_pkg.sv
// Shared types and defaults for the multi-mode counter and its tally sub-blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// mode_e : step selection carried on control_value
// who_e  : encoding of the WHO output (which tally ended the game)
package counter_pkg;

    localparam int CNT_WIDTH_DEF  = 4;
    localparam int GAME_LIMIT_DEF = 15;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UP2 = 2'b01,
        DN1 = 2'b10,
        DN2 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        LOSER  = 2'b01,
        WINNER = 2'b10
    } who_e;

endpackage

// File: rtl/counter_tally.sv
// Event tally for the game layer; flags the event that brings the tally to GAME_LIMIT.
// Latency: tally updates on the edge after i_event; o_done is combinational on that same event.
// Backpressure: none; i_hold freezes the tally and masks o_done.
//
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   i_hold     : freeze the tally (game already over)
//   i_event    : flag value being registered this cycle
//   o_done     : high when this edge's event is the GAME_LIMIT-th one
module counter_tally #(
    parameter int WIDTH      = counter_pkg::CNT_WIDTH_DEF,
    parameter int GAME_LIMIT = counter_pkg::GAME_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_hold,
    input  logic i_event,
    output logic o_done
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_bump;

    assign w_bump = i_event && !i_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_bump) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    // Flag the finishing event before it is registered so the game-over
    // state lands on the same edge as the last WINNER/LOSER flag.
    assign o_done = w_bump && (r_cnt == WIDTH'(GAME_LIMIT - 1));

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down counter (+1/+2/-1/-2) with parallel load and a win/lose game layer.
// Latency: 1 cycle from edge to count and WINNER/LOSER/GAMEOVER/WHO.
// Backpressure: none; GAMEOVER freezes the counter until reset.
//
// Optional feature macro: COUNTER_GAMEOVER_EN (tallies + game-over freeze).
// Without it GAMEOVER/WHO are tied to 0 and the counter never freezes.
//
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   control_value : step mode (00 +1, 01 +2, 10 -1, 11 -2)
//   INIT          : load count_input this cycle (overrides stepping)
//   count_input   : load value
//   count         : registered count
//   WINNER/LOSER  : registered, high while count is all ones / all zeros
//   GAMEOVER      : sticky until reset
//   WHO           : 00 none, 01 loser tally finished, 10 winner tally finished
module multi_mode_counter #(
    parameter int WIDTH      = counter_pkg::CNT_WIDTH_DEF,
    parameter int GAME_LIMIT = counter_pkg::GAME_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       control_value,
    input  logic             INIT,
    input  logic [WIDTH-1:0] count_input,
    output logic [WIDTH-1:0] count,
    output logic             WINNER,
    output logic             LOSER,
    output logic             GAMEOVER,
    output logic [1:0]       WHO
);

    import counter_pkg::*;

    logic [WIDTH-1:0] r_count;
    logic             r_winner;
    logic             r_loser;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_win_nxt;
    logic             w_lose_nxt;
    logic             w_frozen;

    // Negative steps are added as their two's-complement so the wrap is free.
    always_comb begin
        w_step = '0;
        case (mode_e'(control_value))
            UP1: w_step = WIDTH'(1);
            UP2: w_step = WIDTH'(2);
            DN1: w_step = '1;
            DN2: w_step = ~WIDTH'(1);
            default: w_step = '0;
        endcase
        w_next = INIT ? count_input : (r_count + w_step);
    end

    // Flags derive from the value being written, not the current count,
    // so they line up with count in the same cycle.
    assign w_win_nxt  = &w_next;
    assign w_lose_nxt = ~|w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_winner <= 1'b0;
            r_loser  <= 1'b0;
        end else if (w_frozen) begin
            r_winner <= 1'b0;
            r_loser  <= 1'b0;
        end else begin
            r_count  <= w_next;
            r_winner <= w_win_nxt;
            r_loser  <= w_lose_nxt;
        end
    end

    assign count  = r_count;
    assign WINNER = r_winner;
    assign LOSER  = r_loser;

`ifdef COUNTER_GAMEOVER_EN
    logic r_gameover;
    who_e r_who;
    logic w_win_done;
    logic w_lose_done;

    counter_tally #(
        .WIDTH      (WIDTH),
        .GAME_LIMIT (GAME_LIMIT)
    ) u_win_tally (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (r_gameover),
        .i_event (w_win_nxt),
        .o_done  (w_win_done)
    );

    counter_tally #(
        .WIDTH      (WIDTH),
        .GAME_LIMIT (GAME_LIMIT)
    ) u_lose_tally (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (r_gameover),
        .i_event (w_lose_nxt),
        .o_done  (w_lose_done)
    );

    // The flags are mutually exclusive, so at most one done fires per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gameover <= 1'b0;
            r_who      <= counter_pkg::NONE;
        end else if (!r_gameover) begin
            if (w_win_done) begin
                r_gameover <= 1'b1;
                r_who      <= counter_pkg::WINNER;
            end else if (w_lose_done) begin
                r_gameover <= 1'b1;
                r_who      <= counter_pkg::LOSER;
            end
        end
    end

    assign w_frozen = r_gameover;
    assign GAMEOVER = r_gameover;
    assign WHO      = r_who;
`else
    logic w_unused_limit;

    assign w_unused_limit = (GAME_LIMIT == 0);
    assign w_frozen       = 1'b0;
    assign GAMEOVER       = 1'b0;
    assign WHO            = 2'b00;
`endif

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed bench for multi_mode_counter with a cycle-level reference model.
// Each step pushes the model's expectation and pops it after the DUT edge.
module tb_multi_mode_counter;

`ifdef COUNTER_GAMEOVER_EN
    localparam bit GO_EN = 1'b1;
`else
    localparam bit GO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] control_value;
    logic       init;
    logic [3:0] count_input;
    logic [3:0] count;
    logic       winner;
    logic       loser;
    logic       gameover;
    logic [1:0] who;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] count;
        logic       win;
        logic       lose;
        logic       go;
        logic [1:0] who;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int         m_count;
    logic       m_win;
    logic       m_lose;
    logic       m_go;
    logic [1:0] m_who;
    int         m_wc;
    int         m_lc;

    always #5 clk = ~clk;

    multi_mode_counter #(
        .WIDTH      (4),
        .GAME_LIMIT (15)
    ) counter (
        .clk           (clk),
        .reset         (reset),
        .control_value (control_value),
        .INIT          (init),
        .count_input   (count_input),
        .count         (count),
        .WINNER        (winner),
        .LOSER         (loser),
        .GAMEOVER      (gameover),
        .WHO           (who)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit ini, input logic [3:0] val, input logic [1:0] mode);
        int delta;
        if (rst) begin
            m_count = 0; m_win = 0; m_lose = 0; m_go = 0; m_who = 2'b00; m_wc = 0; m_lc = 0;
        end else if (GO_EN && m_go) begin
            m_win  = 0;
            m_lose = 0;
        end else begin
            case (mode)
                2'b00:   delta = 1;
                2'b01:   delta = 2;
                2'b10:   delta = -1;
                default: delta = -2;
            endcase
            if (ini) m_count = int'(val);
            else     m_count = (m_count + delta + 16) % 16;
            m_win  = (m_count == 15);
            m_lose = (m_count == 0);
            if (GO_EN) begin
                if (m_win) begin
                    m_wc++;
                    if (m_wc == 15) begin m_go = 1; m_who = 2'b10; end
                end
                if (m_lose) begin
                    m_lc++;
                    if (m_lc == 15) begin m_go = 1; m_who = 2'b01; end
                end
            end
        end
    endtask

    task automatic tick(input bit rst, input bit ini, input logic [3:0] val, input logic [1:0] mode);
        exp_t e;
        @(negedge clk);
        reset = rst; init = ini; count_input = val; control_value = mode;
        model_step(rst, ini, val, mode);
        e.count = m_count[3:0]; e.win = m_win; e.lose = m_lose; e.go = m_go; e.who = m_who;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("count",    {4'h0, count},    {4'h0, e.count});
        check("winner",   {7'h0, winner},   {7'h0, e.win});
        check("loser",    {7'h0, loser},    {7'h0, e.lose});
        check("gameover", {7'h0, gameover}, {7'h0, e.go});
        check("who",      {6'h0, who},      {6'h0, e.who});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; init = 1'b0; count_input = 4'h0; control_value = 2'b00;

        // Reset state: count 0 yet both flags low
        tick(1, 0, 4'h0, 2'b00);
        tick(1, 0, 4'h0, 2'b00);
        check("rst_count",  {4'h0, count}, 8'h00);
        check("rst_loser",  {7'h0, loser}, 8'h00);

        // +1 eight times, then +2 wrapping to zero
        for (int i = 0; i < 8; i++) tick(0, 0, 4'h0, 2'b00);
        check("plan_up1_8", {4'h0, count}, 8'h08);
        for (int i = 0; i < 4; i++) tick(0, 0, 4'h0, 2'b01);
        check("plan_up2_wrap", {4'h0, count}, 8'h00);
        check("plan_up2_loser", {7'h0, loser}, 8'h01);

        // -1 from 0 reaches 15 with WINNER, then -2 steps
        tick(0, 0, 4'h0, 2'b10);
        check("plan_dn1_15", {4'h0, count}, 8'h0f);
        check("plan_dn1_win", {7'h0, winner}, 8'h01);
        for (int i = 0; i < 3; i++) tick(0, 0, 4'h0, 2'b11);
        check("plan_dn2_9", {4'h0, count}, 8'h09);
        check("plan_dn2_nowin", {7'h0, winner}, 8'h00);

        // Reset mid-count
        tick(1, 0, 4'h0, 2'b11);
        check("midrst_count", {4'h0, count}, 8'h00);

        // Load overrides stepping, then stepping resumes
        tick(0, 1, 4'hd, 2'b11);
        check("load_1101", {4'h0, count}, 8'h0d);
        tick(0, 0, 4'hd, 2'b11);
        check("load_then_dn2", {4'h0, count}, 8'h0b);

        // Held INIT on 1111: one WINNER event per cycle
        tick(0, 1, 4'hf, 2'b00);
        check("hold_init_win1", {7'h0, winner}, 8'h01);
        tick(0, 1, 4'hf, 2'b00);
        check("hold_init_win2", {7'h0, winner}, 8'h01);

        // Load zero: LOSER for one cycle, then count 1
        tick(0, 1, 4'h0, 2'b00);
        check("load0_loser", {7'h0, loser}, 8'h01);
        tick(0, 0, 4'h0, 2'b00);
        check("after_load0", {4'h0, count}, 8'h01);
        check("after_load0_loser", {7'h0, loser}, 8'h00);

        // Winner game: load 1111 then +1 for 15*16 cycles
        tick(1, 0, 4'h0, 2'b00);
        tick(0, 1, 4'hf, 2'b00);
        for (int i = 0; i < 240; i++) tick(0, 0, 4'h0, 2'b00);
        check("win_game_over", {7'h0, gameover}, {7'h0, GO_EN});
        check("win_game_who",  {6'h0, who},      GO_EN ? 8'h02 : 8'h00);
        check("win_game_count", {4'h0, count},   8'h0f);
        tick(0, 1, 4'h0, 2'b00);
        check("frozen_init", {4'h0, count}, GO_EN ? 8'h0f : 8'h00);
        tick(0, 1, 4'h0, 2'b00);
        tick(1, 0, 4'h0, 2'b00);
        check("go_rst_over", {7'h0, gameover}, 8'h00);
        check("go_rst_who",  {6'h0, who},      8'h00);

        // Loser game: load 0000 then -1 for 15*16 cycles
        tick(0, 1, 4'h0, 2'b10);
        for (int i = 0; i < 240; i++) tick(0, 0, 4'h0, 2'b10);
        check("lose_game_over", {7'h0, gameover}, {7'h0, GO_EN});
        check("lose_game_who",  {6'h0, who},      GO_EN ? 8'h01 : 8'h00);
        tick(1, 0, 4'h0, 2'b00);
        tick(0, 0, 4'h0, 2'b00);
        check("restart_count", {4'h0, count}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
